usb_pkt_rx: RTL
===============

# usb_pkt_rx

Receive-side packet decoder between the bit-level receiver and the SIE protocol engine. It consumes the byte stream produced by the low/full-speed receiver and validates the PID and packet length. It checks CRC5 on token packets and CRC16 on data packets. It emits decoded token/SOF fields, handshake PIDs and a CRC-stripped data byte stream, with one terminal status pulse per packet.

## Interface
- `MAX_DATA`, default 1023: maximum data payload bytes; longer packets are errors.
- `clk` in 1: system clock, 24 MHz.
- `reset` in 1: synchronous, active-high.
- `rx_data` in 8: received byte from receiver; first bit on the wire is in bit 0.
- `rx_active` in 1: high from after SYNC until EOP stripped.
- `rx_valid` in 1: one-cycle pulse, `rx_data` valid.
- `rx_error` in 1: receiver error (sticky for the current packet).
- `pid` out 4: PID of last accepted packet; held until next accept.
- `addr` out 7: token/setup device address.
- `endp` out 4: token endpoint.
- `frame` out 11: SOF frame number.
- `token_valid` out 1: pulse, OUT/IN/SETUP token accepted.
- `sof_valid` out 1: pulse, SOF accepted.
- `hsk_valid` out 1: pulse, ACK/NAK/STALL accepted.
- `dout` out 8: payload byte.
- `dout_valid` out 1: pulse per payload byte.
- `data_ok` out 1: pulse, DATA0/1 packet ended with good CRC16.
- `pkt_err` out 1: pulse, packet rejected (any error).

## Operation
- States: IDLE, PID, TOKEN1, TOKEN2, TOKEN_END, DATA, HSK_END, DRAIN.
- IDLE → PID on `rx_active` rising.
- In PID, first `rx_valid` byte: require `rx_data[7:4] == ~rx_data[3:0]`, else DRAIN with error flagged.
  - OUT/IN/SETUP/SOF → TOKEN1.
  - DATA0/DATA1 → DATA.
  - ACK/NAK/STALL → HSK_END.
  - Any other PID (PRE, SPLIT, PING, DATA2, MDATA, ERR, NYET) → DRAIN with error.
- TOKEN1 captures byte 1. TOKEN2 captures byte 2, then → TOKEN_END.
  - Token fields: 11 bits `{b2[2:0],b1}`; `addr = b1[6:0]`, `endp = {b2[2:0],b1[7]}`, `frame = {b2[2:0],b1}`.
  - CRC5 is computed over all 16 bits (LSB first): init 5'h1F, poly 5'h05. Residual must equal 5'b01100.
- DATA: each byte enters a 2-byte delay line, so CRC bytes are never emitted.
  - When the 3rd and later bytes arrive, the oldest buffered byte goes out on `dout`/`dout_valid`.
  - CRC16 runs over all bytes after the PID: init 16'hFFFF, poly 16'h8005, LSB first. Residual must equal 16'h800D.
  - Byte counter is 11 bits and saturates. More than `MAX_DATA`+2 bytes after the PID → error flag; stop emitting.
- Any extra byte in TOKEN_END/HSK_END → error flag.
- `rx_error` seen while not IDLE → error flag.
- `rx_active` falling edge from any non-IDLE state ends the packet. Exactly one status pulse is issued, then → IDLE.
  - Error flag set, wrong length, or bad CRC → `pkt_err`.
  - Otherwise, by class: `token_valid` / `sof_valid` / `hsk_valid` / `data_ok`. `pid` and fields update in the same cycle.
  - Zero-byte packet (fall while in PID) → IDLE, no pulse.
  - Data packet with fewer than 2 bytes after the PID → `pkt_err`.
- `pid`/`addr`/`endp`/`frame` update only on accept. Rejected packets leave them unchanged.
- `dout_valid` bytes of a packet later rejected are still emitted; the consumer discards them on `pkt_err`.

## Timing
- Reset values: all outputs 0; state IDLE; CRC registers at their init values.
- `dout`/`dout_valid` are registered, 1 cycle after the triggering `rx_valid`.
- Status pulses are registered, 1 cycle after the cycle where `rx_active` is sampled low following high. Pulses are exactly 1 cycle wide.
- `rx_valid` in the same cycle as `rx_active` falling: the byte is processed first, then the end of packet.
- `reset` mid-packet: immediate IDLE, no pulse. A packet already in progress when reset releases is not decoded; decoding waits for the next `rx_active` rising edge.
- CRC update is combinational over 8 bits per `rx_valid`. There is no throughput limit: back-to-back `rx_valid` on consecutive cycles is supported.

## Structure
- Shared package `types`:
  - `pid_t` enum (4-bit PID codes).
  - CRC5/CRC16 init, poly and residual constants.
  - `crc5_byte` / `crc16_byte` functions (8-step LSB-first update).
- One sub-module, `usb_crc16`: byte-wide CRC16 register with init/enable/residual-check output. It is reused by the later transmit packet builder.
- CRC5 stays inline.

## Test plan
- SETUP token bytes 2D 00 10 → `token_valid`, `pid`=4'hD, `addr`=0, `endp`=0, no `pkt_err`.
- Same token with last byte 11 → `pkt_err` only; `addr`/`endp` unchanged.
- DATA0 bytes C3 80 06 00 01 00 00 40 00 DD 94 → 8 `dout_valid` pulses carrying 80 06 00 01 00 00 40 00, then `data_ok`.
- Zero-length DATA1 4B 00 00 → no `dout_valid`, `data_ok`, `pid`=4'hB. Then ACK D2 → `hsk_valid`, `pid`=4'h2.
- PID byte D3 (check fails), or `rx_error` asserted mid-DATA0 → `pkt_err`, no accept pulse, returns to IDLE. The following ACK D2 decodes normally.
- `reset` asserted after the 5th byte of a DATA0 → no further outputs, all outputs 0. A subsequent token decodes correctly.

Source files
------------

// File: rtl/usb_pkt_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb_pkt_rx_pkg
// Description : Shared USB packet types, CRC constants and byte-wide CRC
//               update functions for the receive decoder and transmit builder.
// Revision    : 1.0 - initial release
// ============================================================================
package usb_pkt_rx_pkg;

    // 4-bit PID codes (PRE and ERR share one encoding)
    typedef enum logic [3:0] {
        PID_OUT     = 4'h1,
        PID_ACK     = 4'h2,
        PID_DATA0   = 4'h3,
        PID_PING    = 4'h4,
        PID_SOF     = 4'h5,
        PID_NYET    = 4'h6,
        PID_DATA2   = 4'h7,
        PID_SPLIT   = 4'h8,
        PID_IN      = 4'h9,
        PID_NAK     = 4'hA,
        PID_DATA1   = 4'hB,
        PID_PRE_ERR = 4'hC,
        PID_SETUP   = 4'hD,
        PID_STALL   = 4'hE,
        PID_MDATA   = 4'hF
    } pid_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PID       = 3'd1,
        ST_TOKEN1    = 3'd2,
        ST_TOKEN2    = 3'd3,
        ST_TOKEN_END = 3'd4,
        ST_DATA      = 3'd5,
        ST_HSK_END   = 3'd6,
        ST_DRAIN     = 3'd7
    } rx_state_t;

    localparam logic [4:0]  CRC5_INIT      = 5'h1F;
    localparam logic [4:0]  CRC5_POLY      = 5'h05;
    localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

    // Eight serial CRC steps, bit 0 of the byte first (wire order)
    function automatic logic [4:0] crc5_byte(input logic [4:0] crc, input logic [7:0] data);
        logic [4:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (data[i] ^ c[4])
                c = {c[3:0], 1'b0} ^ CRC5_POLY;
            else
                c = {c[3:0], 1'b0};
        end
        return c;
    endfunction

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (data[i] ^ c[15])
                c = {c[14:0], 1'b0} ^ CRC16_POLY;
            else
                c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/usb_crc16.sv
`default_nettype none
// ============================================================================
// Module      : usb_crc16
// Description : Byte-wide USB CRC16 register with init/enable and a residual
//               check on the value being loaded this cycle.
// Revision    : 1.0 - initial release
// Ports       : clk, reset   - clock, synchronous active-high reset
//               init         - load CRC16_INIT (wins over en)
//               en, data     - fold one byte into the CRC
//               res_ok       - next CRC value equals the good-packet residual
// ============================================================================
module usb_crc16
    import usb_pkt_rx_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       init,
    input  logic       en,
    input  logic [7:0] data,
    output logic       res_ok
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (init)
            crc_d = CRC16_INIT;
        else if (en)
            crc_d = crc16_byte(crc_q, data);
    end

    always_ff @(posedge clk) begin
        if (reset)
            crc_q <= CRC16_INIT;
        else
            crc_q <= crc_d;
    end

    // Checked on the next value so a final byte arriving with end-of-packet
    // is already included.
    assign res_ok = (crc_d == CRC16_RESIDUAL);

endmodule
`default_nettype wire

// File: rtl/usb_pkt_rx.sv
`default_nettype none
// ============================================================================
// Module      : usb_pkt_rx
// Description : USB receive packet decoder. Validates PID, length and CRC5/
//               CRC16, emits token/SOF fields, handshake PIDs and CRC-stripped
//               payload bytes, with one status pulse per packet.
// Revision    : 1.0 - initial release
// Ports       : rx_data/rx_active/rx_valid/rx_error - receiver byte stream
//               pid/addr/endp/frame  - fields of the last accepted packet
//               token_valid/sof_valid/hsk_valid/data_ok/pkt_err - status pulses
//               dout/dout_valid      - payload bytes
// ============================================================================
module usb_pkt_rx
    import usb_pkt_rx_pkg::*;
#(
    parameter int MAX_DATA = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_active,
    input  logic        rx_valid,
    input  logic        rx_error,
    output logic [3:0]  pid,
    output logic [6:0]  addr,
    output logic [3:0]  endp,
    output logic [10:0] frame,
    output logic        token_valid,
    output logic        sof_valid,
    output logic        hsk_valid,
    output logic [7:0]  dout,
    output logic        dout_valid,
    output logic        data_ok,
    output logic        pkt_err
);

    rx_state_t   state_q, state_d;
    logic        act_prev_q;
    logic        err_q, err_d;
    logic [3:0]  pid_cand_q, pid_cand_d;
    logic [10:0] field_q, field_d;
    logic [4:0]  crc5_q, crc5_d;
    logic [10:0] cnt_q, cnt_d;
    logic [7:0]  buf0_q, buf0_d, buf1_q, buf1_d;
    logic [3:0]  pid_q, pid_d;
    logic [6:0]  addr_q, addr_d;
    logic [3:0]  endp_q, endp_d;
    logic [10:0] frame_q, frame_d;
    logic [7:0]  dout_q, dout_d;
    logic        dout_valid_q, dout_valid_d;
    logic        token_valid_q, token_valid_d;
    logic        sof_valid_q, sof_valid_d;
    logic        hsk_valid_q, hsk_valid_d;
    logic        data_ok_q, data_ok_d;
    logic        pkt_err_q, pkt_err_d;
    logic        over;

    // act_prev resets high so a packet already running at reset release
    // is not seen as a rising edge.
    wire rx_rise     = rx_active & ~act_prev_q;
    wire rx_fall     = ~rx_active & act_prev_q;
    wire crc16_init  = (state_q == ST_IDLE) & rx_rise;
    wire crc16_en    = (state_q == ST_DATA) & rx_valid;
    logic crc16_ok;

    usb_crc16 u_crc16 (
        .clk    (clk),
        .reset  (reset),
        .init   (crc16_init),
        .en     (crc16_en),
        .data   (rx_data),
        .res_ok (crc16_ok)
    );

    always_comb begin
        state_d       = state_q;
        err_d         = err_q;
        pid_cand_d    = pid_cand_q;
        field_d       = field_q;
        crc5_d        = crc5_q;
        cnt_d         = cnt_q;
        buf0_d        = buf0_q;
        buf1_d        = buf1_q;
        pid_d         = pid_q;
        addr_d        = addr_q;
        endp_d        = endp_q;
        frame_d       = frame_q;
        dout_d        = dout_q;
        dout_valid_d  = 1'b0;
        token_valid_d = 1'b0;
        sof_valid_d   = 1'b0;
        hsk_valid_d   = 1'b0;
        data_ok_d     = 1'b0;
        pkt_err_d     = 1'b0;
        over          = 1'b0;

        // Byte handling for the current state
        case (state_q)
            ST_IDLE: begin
                if (rx_rise) begin
                    state_d = ST_PID;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    crc5_d  = CRC5_INIT;
                end
            end
            ST_PID: begin
                if (rx_valid) begin
                    pid_cand_d = rx_data[3:0];
                    if (rx_data[7:4] != ~rx_data[3:0]) begin
                        state_d = ST_DRAIN;
                        err_d   = 1'b1;
                    end else begin
                        case (rx_data[3:0])
                            PID_OUT, PID_IN, PID_SETUP, PID_SOF: state_d = ST_TOKEN1;
                            PID_DATA0, PID_DATA1:                state_d = ST_DATA;
                            PID_ACK, PID_NAK, PID_STALL:         state_d = ST_HSK_END;
                            default: begin
                                state_d = ST_DRAIN;
                                err_d   = 1'b1;
                            end
                        endcase
                    end
                end
            end
            ST_TOKEN1: begin
                if (rx_valid) begin
                    field_d[7:0] = rx_data;
                    crc5_d       = crc5_byte(crc5_q, rx_data);
                    state_d      = ST_TOKEN2;
                end
            end
            ST_TOKEN2: begin
                if (rx_valid) begin
                    field_d[10:8] = rx_data[2:0];
                    crc5_d        = crc5_byte(crc5_q, rx_data);
                    state_d       = ST_TOKEN_END;
                end
            end
            ST_TOKEN_END, ST_HSK_END: begin
                if (rx_valid)
                    err_d = 1'b1;
            end
            ST_DATA: begin
                if (rx_valid) begin
                    cnt_d  = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
                    over   = int'(cnt_d) > MAX_DATA + 2;
                    // Two-byte delay line holds back the trailing CRC bytes
                    buf1_d = buf0_q;
                    buf0_d = rx_data;
                    if (over)
                        err_d = 1'b1;
                    else if (cnt_q >= 11'd2) begin
                        dout_d       = buf1_q;
                        dout_valid_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        if (state_q != ST_IDLE) begin
            if (rx_error)
                err_d = 1'b1;
            // End of packet: classify on the state reached after any byte
            // that arrived in this same cycle.
            if (rx_fall) begin
                case (state_d)
                    ST_PID: ;
                    ST_TOKEN_END: begin
                        if (err_d || crc5_d != CRC5_RESIDUAL)
                            pkt_err_d = 1'b1;
                        else begin
                            pid_d = pid_cand_d;
                            if (pid_cand_d == PID_SOF) begin
                                sof_valid_d = 1'b1;
                                frame_d     = field_d;
                            end else begin
                                token_valid_d = 1'b1;
                                addr_d        = field_d[6:0];
                                endp_d        = field_d[10:7];
                            end
                        end
                    end
                    ST_DATA: begin
                        if (err_d || cnt_d < 11'd2 || !crc16_ok)
                            pkt_err_d = 1'b1;
                        else begin
                            data_ok_d = 1'b1;
                            pid_d     = pid_cand_d;
                        end
                    end
                    ST_HSK_END: begin
                        if (err_d)
                            pkt_err_d = 1'b1;
                        else begin
                            hsk_valid_d = 1'b1;
                            pid_d       = pid_cand_d;
                        end
                    end
                    default: pkt_err_d = 1'b1;
                endcase
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            act_prev_q    <= 1'b1;
            err_q         <= 1'b0;
            pid_cand_q    <= '0;
            field_q       <= '0;
            crc5_q        <= CRC5_INIT;
            cnt_q         <= '0;
            buf0_q        <= '0;
            buf1_q        <= '0;
            pid_q         <= '0;
            addr_q        <= '0;
            endp_q        <= '0;
            frame_q       <= '0;
            dout_q        <= '0;
            dout_valid_q  <= 1'b0;
            token_valid_q <= 1'b0;
            sof_valid_q   <= 1'b0;
            hsk_valid_q   <= 1'b0;
            data_ok_q     <= 1'b0;
            pkt_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            act_prev_q    <= rx_active;
            err_q         <= err_d;
            pid_cand_q    <= pid_cand_d;
            field_q       <= field_d;
            crc5_q        <= crc5_d;
            cnt_q         <= cnt_d;
            buf0_q        <= buf0_d;
            buf1_q        <= buf1_d;
            pid_q         <= pid_d;
            addr_q        <= addr_d;
            endp_q        <= endp_d;
            frame_q       <= frame_d;
            dout_q        <= dout_d;
            dout_valid_q  <= dout_valid_d;
            token_valid_q <= token_valid_d;
            sof_valid_q   <= sof_valid_d;
            hsk_valid_q   <= hsk_valid_d;
            data_ok_q     <= data_ok_d;
            pkt_err_q     <= pkt_err_d;
        end
    end

    assign pid         = pid_q;
    assign addr        = addr_q;
    assign endp        = endp_q;
    assign frame       = frame_q;
    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign token_valid = token_valid_q;
    assign sof_valid   = sof_valid_q;
    assign hsk_valid   = hsk_valid_q;
    assign data_ok     = data_ok_q;
    assign pkt_err     = pkt_err_q;

endmodule
`default_nettype wire
